// File: rtl/memory_stage_lsu.sv
// Memory stage: performs data-memory loads/stores over a req/ack bus,
// stalls upstream while an access is outstanding and drives MEM/WB.
module memory_stage_lsu #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_alures,
  input  logic [31:0] i_busB,
  input  logic [4:0]  i_Rw,
  input  logic [1:0]  i_M,
  input  logic        i_WB,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_stall,
  output logic [31:0] o_wb_data,
  output logic [4:0]  o_Rw,
  output logic        o_WB,
  output logic        o_mem_fault,
  output logic        o_bus_err
);

  typedef enum logic {IDLE, WAIT} state_t;

  // Last counter value before the access is abandoned; unused when TIMEOUT=0.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       rw_hold;
  logic             wb_hold;
  logic             ld_hold;
  logic             is_mem, aligned, start, fault, tmo;

  // Decode the presented instruction, derive stall and the next FSM state.
  always_comb begin
    is_mem    = (i_M == 2'b01) || (i_M == 2'b10);
    aligned   = (i_alures[1:0] == 2'b00);
    start     = (state == IDLE) && is_mem && aligned;
    fault     = (state == IDLE) && (i_M != 2'b00) && !(is_mem && aligned);
    tmo       = (TIMEOUT > 0) && (state == WAIT) && !i_mem_ack && (cnt == TMO_LAST);
    // Stall is forced low in reset so every output reads 0 while reset is held.
    o_stall   = i_rst_n && (start || ((state == WAIT) && !i_mem_ack && !tmo));
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = WAIT;
      WAIT:    if (i_mem_ack || tmo) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Bus request, captured instruction fields, timeout counter and MEM/WB register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_wb_data   <= '0;
      o_Rw        <= '0;
      o_WB        <= 1'b0;
      o_mem_fault <= 1'b0;
      o_bus_err   <= 1'b0;
      cnt         <= '0;
      rw_hold     <= '0;
      wb_hold     <= 1'b0;
      ld_hold     <= 1'b0;
    end else begin
      o_mem_fault <= 1'b0;
      o_bus_err   <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          o_mem_req   <= 1'b1;
          o_mem_we    <= i_M[0];
          o_mem_addr  <= i_alures;
          o_mem_wdata <= i_busB;
          rw_hold     <= i_Rw;
          wb_hold     <= i_WB;
          ld_hold     <= i_M[1];
          cnt         <= '0;
          o_wb_data   <= '0;
          o_Rw        <= '0;
          o_WB        <= 1'b0;
        end else if (fault) begin
          o_mem_fault <= 1'b1;
          o_wb_data   <= '0;
          o_Rw        <= '0;
          o_WB        <= 1'b0;
        end else begin
          o_wb_data   <= i_alures;
          o_Rw        <= i_Rw;
          o_WB        <= i_WB;
        end
      end else begin
        if (i_mem_ack) begin
          // Ack has priority over a coincident timeout.
          o_mem_req <= 1'b0;
          o_wb_data <= ld_hold ? i_mem_rdata : o_mem_addr;
          o_Rw      <= rw_hold;
          o_WB      <= wb_hold;
        end else if (tmo) begin
          o_mem_req <= 1'b0;
          o_bus_err <= 1'b1;
          o_wb_data <= '0;
          o_Rw      <= rw_hold;
          o_WB      <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule
